// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared ALUOp encodings, register-index width and control bundle
package id_ex_stage_pkg;
    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_IMM   = 2'b11
    } aluop_e;

    typedef struct packed {
        logic   RegWrite;
        logic   MemToReg;
        logic   MemRead;
        logic   MemWrite;
        logic   ALUSrc;
        logic   RegDst;
        aluop_e ALUOp;
    } ctrl_t;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side inputs and EX-side registered outputs of the ID/EX register
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic              ID_Valid_i;
    logic [REG_W-1:0]  ID_RegRS_i, ID_RegRT_i, ID_RegRD_i;
    logic [DATA_W-1:0] ID_Data1_i, ID_Data2_i, ID_SignExt_i;
    logic              ID_RegWrite_i, ID_MemToReg_i, ID_MemRead_i, ID_MemWrite_i, ID_ALUSrc_i, ID_RegDst_i;
    logic [1:0]        ID_ALUOp_i;
    logic              IE_Valid_o;
    logic [REG_W-1:0]  IE_RegRS_o, IE_RegRT_o, IE_RegRD_o;
    logic [DATA_W-1:0] IE_Data1_o, IE_Data2_o, IE_SignExt_o;
    logic              IE_RegWrite_o, IE_MemToReg_o, IE_MemRead_o, IE_MemWrite_o, IE_ALUSrc_o, IE_RegDst_o;
    logic [1:0]        IE_ALUOp_o;

    modport master (
        output ID_Valid_i, ID_RegRS_i, ID_RegRT_i, ID_RegRD_i, ID_Data1_i, ID_Data2_i, ID_SignExt_i,
               ID_RegWrite_i, ID_MemToReg_i, ID_MemRead_i, ID_MemWrite_i, ID_ALUSrc_i, ID_RegDst_i, ID_ALUOp_i,
        input  IE_Valid_o, IE_RegRS_o, IE_RegRT_o, IE_RegRD_o, IE_Data1_o, IE_Data2_o, IE_SignExt_o,
               IE_RegWrite_o, IE_MemToReg_o, IE_MemRead_o, IE_MemWrite_o, IE_ALUSrc_o, IE_RegDst_o, IE_ALUOp_o
    );

    modport slave (
        input  ID_Valid_i, ID_RegRS_i, ID_RegRT_i, ID_RegRD_i, ID_Data1_i, ID_Data2_i, ID_SignExt_i,
               ID_RegWrite_i, ID_MemToReg_i, ID_MemRead_i, ID_MemWrite_i, ID_ALUSrc_i, ID_RegDst_i, ID_ALUOp_i,
        output IE_Valid_o, IE_RegRS_o, IE_RegRT_o, IE_RegRD_o, IE_Data1_o, IE_Data2_o, IE_SignExt_o,
               IE_RegWrite_o, IE_MemToReg_o, IE_MemRead_o, IE_MemWrite_o, IE_ALUSrc_o, IE_RegDst_o, IE_ALUOp_o
    );
endinterface

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load now in EX
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic             i_ie_valid,
    input  logic             i_ie_memread,
    input  logic [REG_W-1:0] i_ie_rt,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_flush,
    output logic             o_hazard
);
    // $0 never carries a dependency, and a flushed ID instruction needs no stall
    always_comb begin
        o_hazard = i_ie_valid & i_ie_memread & (i_ie_rt != '0) & i_id_valid &
                   ((i_ie_rt == i_id_rs) | (i_ie_rt == i_id_rt)) & ~i_flush;
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion and bubble counter
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32
)(
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         stall_i,
    input  logic         flush_i,
    id_ex_stage_if.slave bus,
    output logic         HazardStall_o,
    output logic [15:0]  BubbleCnt_o
);
    logic              r_valid;
    logic [REG_W-1:0]  r_rs, r_rt, r_rd;
    logic [DATA_W-1:0] r_d1, r_d2, r_imm;
    ctrl_t             r_ctrl;
    logic [15:0]       r_cnt;
    ctrl_t             w_id_ctrl;
    logic              w_bubble;

    assign w_id_ctrl = '{RegWrite: bus.ID_RegWrite_i, MemToReg: bus.ID_MemToReg_i, MemRead: bus.ID_MemRead_i,
                         MemWrite: bus.ID_MemWrite_i, ALUSrc: bus.ID_ALUSrc_i, RegDst: bus.ID_RegDst_i,
                         ALUOp: aluop_e'(bus.ID_ALUOp_i)};
    assign w_bubble  = flush_i | HazardStall_o;

    load_use_detect u_detect (
        .i_ie_valid   (r_valid),
        .i_ie_memread (r_ctrl.MemRead),
        .i_ie_rt      (r_rt),
        .i_id_valid   (bus.ID_Valid_i),
        .i_id_rs      (bus.ID_RegRS_i),
        .i_id_rt      (bus.ID_RegRT_i),
        .i_flush      (flush_i),
        .o_hazard     (HazardStall_o)
    );

    // Stall freezes everything; a bubble kills side effects and register ids; otherwise load ID
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid <= 1'b0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_d1    <= '0;
            r_d2    <= '0;
            r_imm   <= '0;
            r_ctrl  <= '0;
            r_cnt   <= '0;
        end else if (!stall_i) begin
            if (w_bubble) begin
                r_valid         <= 1'b0;
                r_ctrl.RegWrite <= 1'b0;
                r_ctrl.MemRead  <= 1'b0;
                r_ctrl.MemWrite <= 1'b0;
                r_ctrl.MemToReg <= 1'b0;
                r_rs            <= '0;
                r_rt            <= '0;
                r_rd            <= '0;
                r_cnt           <= (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
            end else begin
                r_valid <= bus.ID_Valid_i;
                r_rs    <= bus.ID_RegRS_i;
                r_rt    <= bus.ID_RegRT_i;
                r_rd    <= bus.ID_RegRD_i;
                r_d1    <= bus.ID_Data1_i;
                r_d2    <= bus.ID_Data2_i;
                r_imm   <= bus.ID_SignExt_i;
                r_ctrl  <= w_id_ctrl;
            end
        end
    end

    assign bus.IE_Valid_o    = r_valid;
    assign bus.IE_RegRS_o    = r_rs;
    assign bus.IE_RegRT_o    = r_rt;
    assign bus.IE_RegRD_o    = r_rd;
    assign bus.IE_Data1_o    = r_d1;
    assign bus.IE_Data2_o    = r_d2;
    assign bus.IE_SignExt_o  = r_imm;
    assign bus.IE_RegWrite_o = r_ctrl.RegWrite;
    assign bus.IE_MemToReg_o = r_ctrl.MemToReg;
    assign bus.IE_MemRead_o  = r_ctrl.MemRead;
    assign bus.IE_MemWrite_o = r_ctrl.MemWrite;
    assign bus.IE_ALUSrc_o   = r_ctrl.ALUSrc;
    assign bus.IE_RegDst_o   = r_ctrl.RegDst;
    assign bus.IE_ALUOp_o    = r_ctrl.ALUOp;
    assign BubbleCnt_o       = r_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors for load-use stalls, flush, freeze, async reset and counter saturation
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        hazard;
    logic [15:0] cnt;
    int          n_cmp = 0;
    int          n_err = 0;

    id_ex_stage_if #(.DATA_W(32)) bus ();

    id_ex_stage #(.DATA_W(32)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .stall_i       (stall),
        .flush_i       (flush),
        .bus           (bus),
        .HazardStall_o (hazard),
        .BubbleCnt_o   (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic rw, input logic m2r, input logic mr, input logic mw,
                          input logic as, input logic rdst, input logic [1:0] op,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
        bus.ID_Valid_i    = v;
        bus.ID_RegRS_i    = rs;
        bus.ID_RegRT_i    = rt;
        bus.ID_RegRD_i    = rd;
        bus.ID_RegWrite_i = rw;
        bus.ID_MemToReg_i = m2r;
        bus.ID_MemRead_i  = mr;
        bus.ID_MemWrite_i = mw;
        bus.ID_ALUSrc_i   = as;
        bus.ID_RegDst_i   = rdst;
        bus.ID_ALUOp_i    = op;
        bus.ID_Data1_i    = d1;
        bus.ID_Data2_i    = d2;
        bus.ID_SignExt_i  = imm;
    endtask

    task automatic id_lw(input logic [4:0] rt, input logic [31:0] d1);
        set_id(1, 5'd2, rt, 5'd0, 1, 1, 1, 0, 1, 0, 2'b00, d1, 32'd200, 32'd4);
    endtask

    task automatic id_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] d1);
        set_id(1, rs, rt, rd, 1, 0, 0, 0, 0, 1, 2'b10, d1, 32'd9, 32'd0);
    endtask

    initial begin
        id_lw(5'd8, 32'd100);
        #3;
        check("rst_valid", 32'(bus.IE_Valid_o), 32'd0);
        check("rst_rt", 32'(bus.IE_RegRT_o), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_hazard", 32'(hazard), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("lw_valid", 32'(bus.IE_Valid_o), 32'd1);
        check("lw_rt", 32'(bus.IE_RegRT_o), 32'd8);
        check("lw_memread", 32'(bus.IE_MemRead_o), 32'd1);
        check("lw_data1", bus.IE_Data1_o, 32'd100);
        check("lw_imm", bus.IE_SignExt_o, 32'd4);
        check("lw_alusrc", 32'(bus.IE_ALUSrc_o), 32'd1);
        id_add(5'd8, 5'd1, 5'd9, 32'd7);
        #1;
        check("lu_hazard", 32'(hazard), 32'd1);
        tick();
        check("lu_bub_valid", 32'(bus.IE_Valid_o), 32'd0);
        check("lu_bub_cnt", 32'(cnt), 32'd1);
        check("lu_bub_rt", 32'(bus.IE_RegRT_o), 32'd0);
        check("lu_bub_memread", 32'(bus.IE_MemRead_o), 32'd0);
        check("lu_bub_regwrite", 32'(bus.IE_RegWrite_o), 32'd0);
        check("lu_bub_hazard", 32'(hazard), 32'd0);
        tick();
        check("lu_add_valid", 32'(bus.IE_Valid_o), 32'd1);
        check("lu_add_rd", 32'(bus.IE_RegRD_o), 32'd9);
        check("lu_add_aluop", 32'(bus.IE_ALUOp_o), 32'd2);
        check("lu_add_regdst", 32'(bus.IE_RegDst_o), 32'd1);
        check("lu_add_hazard", 32'(hazard), 32'd0);
        check("lu_add_cnt", 32'(cnt), 32'd1);

        pulse_reset();
        id_lw(5'd8, 32'd100);
        tick();
        id_add(5'd8, 5'd1, 5'd9, 32'd7);
        flush = 1'b1;
        #1;
        check("fl_hazard", 32'(hazard), 32'd0);
        tick();
        flush = 1'b0;
        check("fl_valid", 32'(bus.IE_Valid_o), 32'd0);
        check("fl_cnt", 32'(cnt), 32'd1);

        pulse_reset();
        id_lw(5'd0, 32'd100);
        tick();
        id_add(5'd0, 5'd0, 5'd11, 32'd3);
        #1;
        check("z_hazard", 32'(hazard), 32'd0);
        tick();
        check("z_valid", 32'(bus.IE_Valid_o), 32'd1);
        check("z_rd", 32'(bus.IE_RegRD_o), 32'd11);
        check("z_cnt", 32'(cnt), 32'd0);

        pulse_reset();
        id_lw(5'd8, 32'd55);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_add(5'd8, 5'd1, 5'(9 + i), 32'(60 + i));
            #1;
            check("st_hazard", 32'(hazard), 32'd1);
            tick();
            check("st_rt", 32'(bus.IE_RegRT_o), 32'd8);
            check("st_data1", bus.IE_Data1_o, 32'd55);
            check("st_cnt", 32'(cnt), 32'd0);
        end
        stall = 1'b0;
        id_add(5'd3, 5'd4, 5'd10, 32'd77);
        #1;
        check("st_rel_hazard", 32'(hazard), 32'd0);
        tick();
        check("st_rel_rd", 32'(bus.IE_RegRD_o), 32'd10);
        check("st_rel_data1", bus.IE_Data1_o, 32'd77);
        check("st_rel_valid", 32'(bus.IE_Valid_o), 32'd1);

        pulse_reset();
        id_lw(5'd8, 32'd100);
        tick();
        id_add(5'd8, 5'd1, 5'd9, 32'd7);
        tick();
        id_lw(5'd8, 32'd100);
        tick();
        id_add(5'd8, 5'd1, 5'd9, 32'd7);
        #1;
        check("ar_pre_hazard", 32'(hazard), 32'd1);
        check("ar_pre_cnt", 32'(cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(bus.IE_Valid_o), 32'd0);
        check("ar_memread", 32'(bus.IE_MemRead_o), 32'd0);
        check("ar_cnt", 32'(cnt), 32'd0);
        check("ar_hazard", 32'(hazard), 32'd0);
        rst_n = 1'b1;
        tick();
        check("ar_load_valid", 32'(bus.IE_Valid_o), 32'd1);
        check("ar_load_rd", 32'(bus.IE_RegRD_o), 32'd9);
        check("ar_load_cnt", 32'(cnt), 32'd0);

        pulse_reset();
        flush = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        check("sat_fffe", 32'(cnt), 32'h0000FFFE);
        tick();
        check("sat_ffff", 32'(cnt), 32'h0000FFFF);
        for (int i = 0; i < 5; i++) tick();
        check("sat_hold", 32'(cnt), 32'h0000FFFF);
        check("sat_valid", 32'(bus.IE_Valid_o), 32'd0);
        flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
